// File: rtl/stepper_move_ctrl.sv
// Stepper move sequencer: paced steps, coil phase, signed position, busy/done.
// Ports: clk, rst, cmd_valid/ready/dir/count/period, abort -> phase, step_pulse,
// position, busy, done. Define STEPPER_HALF_STEP_EN for the 8-entry half-step table.
module stepper_move_ctrl #(
  parameter int CNT_W = 7,
  parameter int DIV_W = 16,
  parameter int POS_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  output logic [3:0]       phase,
  output logic             step_pulse,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             done
);

`ifdef STEPPER_HALF_STEP_EN
  localparam int IDX_W = 3;
`else
  localparam int IDX_W = 2;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       phase_q, phase_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             pulse_q, pulse_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic [DIV_W-1:0] per_eff;

  // Index wraps naturally at 2^IDX_W, which is the table length.
  function automatic logic [3:0] phase_lut(
    input logic [IDX_W-1:0] idx
  );
    logic [3:0] pat;
`ifdef STEPPER_HALF_STEP_EN
    unique case (idx)
      3'd0:    pat = 4'b0001;
      3'd1:    pat = 4'b0011;
      3'd2:    pat = 4'b0010;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0100;
      3'd5:    pat = 4'b1100;
      3'd6:    pat = 4'b1000;
      default: pat = 4'b1001;
    endcase
`else
    unique case (idx)
      2'd0:    pat = 4'b0001;
      2'd1:    pat = 4'b0010;
      2'd2:    pat = 4'b0100;
      default: pat = 4'b1000;
    endcase
`endif
    return pat;
  endfunction

  assign per_eff = (cmd_period == '0)
                 ? DIV_W'(1) : cmd_period;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    per_d   = per_q;
    div_d   = div_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    pos_d   = pos_q;
    pulse_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          dir_d = cmd_dir;
          per_d = per_eff;
          div_d = per_eff - DIV_W'(1);
          rem_d = cmd_count;
          state_d = (cmd_count == '0)
                  ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Abort beats a step falling due the same cycle.
        if (abort) begin
          state_d = S_DONE;
        end else if (div_q == '0) begin
          div_d   = per_q - DIV_W'(1);
          rem_d   = rem_q - CNT_W'(1);
          pulse_d = 1'b1;
          if (dir_q) begin
            idx_d = idx_q + IDX_W'(1);
            pos_d = pos_q + POS_W'(1);
          end else begin
            idx_d = idx_q - IDX_W'(1);
            pos_d = pos_q - POS_W'(1);
          end
          if (rem_q == CNT_W'(1))
            state_d = S_DONE;
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    phase_d = phase_lut(idx_d);
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      per_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      phase_q <= 4'b0001;
      pos_q   <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      per_q   <= per_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign phase      = phase_q;
  assign step_pulse = pulse_q;
  assign position   = pos_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Scoreboard bench for stepper_move_ctrl: reference model predicts
// every pulse/done event (cycle, position, phase); monitor compares.
module tb_stepper_move_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [6:0]  cmd_count = '0;
  logic [15:0] cmd_period = '0;
  logic        abort = 1'b0;
  logic [3:0]  phase;
  logic        step_pulse;
  logic [15:0] position;
  logic        busy;
  logic        done;

  stepper_move_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_count(cmd_count),
    .cmd_period(cmd_period), .abort(abort),
    .phase(phase), .step_pulse(step_pulse),
    .position(position), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    bit          pulse;
    bit          dn;
    logic [15:0] pos;
    logic [3:0]  ph;
  } ev_t;

  ev_t sb[$];

  // Reference model: position as an integer, phase as a table index.
`ifdef STEPPER_HALF_STEP_EN
  localparam int NPH = 8;
`else
  localparam int NPH = 4;
`endif
  int m_pos = 0;
  int m_idx = 0;

  function automatic logic [3:0] ref_phase(input int i);
    logic [3:0] full_t [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
    logic [3:0] half_t [8] = '{4'h1, 4'h3, 4'h2, 4'h6,
                               4'h4, 4'hC, 4'h8, 4'h9};
    return (NPH == 8) ? half_t[i] : full_t[i];
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (step_pulse === 1'b1 || done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: pulse=%b done=%b cyc %0d",
                 step_pulse, done, cyc);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("ev_cycle", cyc, e.cyc);
        chk("ev_pulse", step_pulse, e.pulse);
        chk("ev_done", done, e.dn);
        chk("ev_pos", position, e.pos);
        chk("ev_phase", phase, e.ph);
      end
    end
  end

  task automatic model_step(input bit d);
    m_pos = d ? m_pos + 1 : m_pos - 1;
    m_idx = d ? (m_idx + 1) % NPH : (m_idx + NPH - 1) % NPH;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_phase"}, phase, 4'b0001);
    chk({tag, "_pos"}, position, 16'd0);
    chk({tag, "_ready"}, cmd_ready, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_pulse"}, step_pulse, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;
    m_pos = 0;
    m_idx = 0;
  endtask

  // Entered and left at a negedge in an idle cycle.
  task automatic run_cmd(input bit d, input int cnt,
                         input int per, input int abk);
    int a, p, dcyc, acyc;
    bit ab;
    ev_t e;
    chk("idle_ready", cmd_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
    cmd_valid  = 1'b1;
    cmd_dir    = d;
    cmd_count  = 7'(cnt);
    cmd_period = 16'(per);
    abort      = 1'($urandom_range(0, 1));
    a = cyc + 1;
    p = (per == 0) ? 1 : per;
    ab = (abk >= 0) && (cnt > 0);
    acyc = -1;
    if (cnt == 0) begin
      dcyc = a;
    end else if (ab) begin
      for (int i = 0; i < abk; i++) begin
        model_step(d);
        e = '{a + p + i * p, 1'b1, 1'b0,
              16'(m_pos), ref_phase(m_idx)};
        sb.push_back(e);
      end
      dcyc = a + p + abk * p;
      acyc = dcyc - 1;
    end else begin
      for (int i = 0; i < cnt; i++) begin
        model_step(d);
        e = '{a + p + i * p, 1'b1, (i == cnt - 1),
              16'(m_pos), ref_phase(m_idx)};
        sb.push_back(e);
      end
      dcyc = a + cnt * p;
    end
    if (cnt == 0 || ab) begin
      e = '{dcyc, 1'b0, 1'b1,
            16'(m_pos), ref_phase(m_idx)};
      sb.push_back(e);
    end
    do begin
      @(negedge clk);
      chk("run_busy", busy, 1'b1);
      chk("run_ready", cmd_ready, 1'b0);
      if (cyc < dcyc) begin
        cmd_valid  = 1'($urandom_range(0, 1));
        cmd_dir    = 1'($urandom_range(0, 1));
        cmd_count  = 7'($urandom_range(0, 127));
        cmd_period = 16'($urandom_range(0, 9));
        abort      = ab && (cyc == acyc);
      end else begin
        cmd_valid = 1'b0;
        abort     = 1'($urandom_range(0, 1));
      end
    end while (cyc < dcyc);
    @(negedge clk);
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  initial begin
    int a;
    ev_t e;
    do_reset();

    run_cmd(1'b1, 5, 3, -1);
    chk("t2_pos", position, 16'd5);
`ifdef STEPPER_HALF_STEP_EN
    chk("t2_phase", phase, 4'b1100);
`else
    chk("t2_phase", phase, 4'b0010);
`endif

    do_reset();
    run_cmd(1'b0, 3, 0, -1);
    chk("t3_pos", position, 16'hFFFD);
`ifdef STEPPER_HALF_STEP_EN
    chk("t3_phase", phase, 4'b1100);
`else
    chk("t3_phase", phase, 4'b0010);
`endif

    run_cmd(1'b1, 0, 10, -1);
    run_cmd(1'b1, 100, 4, 2);
    chk("t5_pos", position, 16'hFFFF);

    do_reset();
    cmd_valid  = 1'b1;
    cmd_dir    = 1'b1;
    cmd_count  = 7'd10;
    cmd_period = 16'd2;
    a = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      model_step(1'b1);
      e = '{a + 2 + 2 * i, 1'b1, 1'b0,
            16'(m_pos), ref_phase(m_idx)};
      sb.push_back(e);
    end
    do begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end while (cyc < a + 4);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("t6");
    rst = 1'b0;
    m_pos = 0;
    m_idx = 0;
    repeat (12) @(negedge clk);
    run_cmd(1'b1, 2, 1, -1);
    chk("t6_pos", position, 16'd2);

    run_cmd(1'b0, 127, 1, -1);

    for (int n = 0; n < 30; n++) begin
      int c, pr, ak;
      c  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 14);
      pr = $urandom_range(0, 5);
      ak = (c > 0 && $urandom_range(0, 3) == 0)
         ? $urandom_range(0, c - 1) : -1;
      run_cmd(1'($urandom_range(0, 1)), c, pr, ak);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: no finish by cyc %0d", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
